// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states,
// default latencies and the HI/LO result payload.
package mdu_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OP_W  = 3;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    localparam logic [OP_W-1:0] MDU_NONE  = 3'b000;
    localparam logic [OP_W-1:0] MDU_MULT  = 3'b001;
    localparam logic [OP_W-1:0] MDU_MULTU = 3'b010;
    localparam logic [OP_W-1:0] MDU_DIV   = 3'b011;
    localparam logic [OP_W-1:0] MDU_DIVU  = 3'b100;
    localparam logic [OP_W-1:0] MDU_MTHI  = 3'b101;
    localparam logic [OP_W-1:0] MDU_MTLO  = 3'b110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } mdu_res_t;

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational multiply/divide datapath operating on the latched operands.
// Signed division goes through magnitudes so INT_MIN / -1 wraps instead of trapping.
module mdu_core
    import mdu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output mdu_res_t        o_res_c,
    output logic            o_div_by_zero_c
);

    logic [2*XLEN-1:0] w_prod_s;
    logic [2*XLEN-1:0] w_prod_u;
    logic              w_signed_div;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN-1:0]   w_div_b;
    logic [XLEN-1:0]   w_q_u;
    logic [XLEN-1:0]   w_r_u;
    logic [XLEN-1:0]   w_q;
    logic [XLEN-1:0]   w_r;

    assign w_prod_s = $signed({{XLEN{i_a[XLEN-1]}}, i_a}) * $signed({{XLEN{i_b[XLEN-1]}}, i_b});
    assign w_prod_u = {XLEN'(0), i_a} * {XLEN'(0), i_b};

    assign w_signed_div = (i_op == MDU_DIV);
    assign w_mag_a = (w_signed_div && i_a[XLEN-1]) ? (~i_a + XLEN'(1)) : i_a;
    assign w_mag_b = (w_signed_div && i_b[XLEN-1]) ? (~i_b + XLEN'(1)) : i_b;
    // Substitute 1 for a zero divisor; the result is discarded at commit anyway.
    assign w_div_b = (w_mag_b == '0) ? XLEN'(1) : w_mag_b;
    assign w_q_u   = w_mag_a / w_div_b;
    assign w_r_u   = w_mag_a % w_div_b;

    assign w_q = (w_signed_div && (i_a[XLEN-1] ^ i_b[XLEN-1])) ? (~w_q_u + XLEN'(1)) : w_q_u;
    assign w_r = (w_signed_div && i_a[XLEN-1]) ? (~w_r_u + XLEN'(1)) : w_r_u;

    always_comb begin
        o_res_c         = '0;
        o_div_by_zero_c = is_div(i_op) && (i_b == '0);
        case (i_op)
            MDU_MULT:           o_res_c = mdu_res_t'(w_prod_s);
            MDU_MULTU:          o_res_c = mdu_res_t'(w_prod_u);
            MDU_DIV, MDU_DIVU: begin
                o_res_c.hi = w_r;
                o_res_c.lo = w_q;
            end
            default:            o_res_c = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU sequencer: accepts one op at a time, holds Busy for a fixed
// latency, then commits the result to HI/LO. Also services mthi/mtlo.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [OP_W-1:0] MDUOp,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            Busy,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [OP_W-1:0]  r_op;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic             r_busy;
    logic [XLEN-1:0]  w_hi_nxt;
    logic [XLEN-1:0]  w_lo_nxt;
    logic             w_latch;
    mdu_res_t         w_res;
    logic             w_div_by_zero;

    mdu_core u_core (
        .i_op            (r_op),
        .i_a             (r_a),
        .i_b             (r_b),
        .o_res_c         (w_res),
        .o_div_by_zero_c (w_div_by_zero)
    );

    // Next-state, counter and HI/LO update; Start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        MDU_MULT, MDU_MULTU: begin
                            w_latch     = 1'b1;
                            w_cnt_nxt   = MULT_LOAD;
                            w_state_nxt = ST_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            w_latch     = 1'b1;
                            w_cnt_nxt   = DIV_LOAD;
                            w_state_nxt = ST_RUN;
                        end
                        MDU_MTHI: w_hi_nxt = A;
                        MDU_MTLO: w_lo_nxt = A;
                        default:  w_latch  = 1'b0;
                    endcase
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    if (!w_div_by_zero) begin
                        w_hi_nxt = w_res.hi;
                        w_lo_nxt = w_res.lo;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MDU_NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            if (w_latch) begin
                r_op <= MDUOp;
                r_a  <= A;
                r_b  <= B;
            end
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a cycle-level reference model compared every cycle.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of an op: {valid, hi, lo}; valid=0 means HI/LO untouched.
    function automatic logic [64:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        int     sa;
        int     sb;
        int     q;
        int     rem;
        logic [63:0] r;
        r = '0;
        case (op)
            MDU_MULT: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                r  = pa * pb;
            end
            MDU_MULTU: r = 64'(a) * 64'(b);
            MDU_DIV: begin
                if (b == 0) return {1'b0, 64'd0};
                sa = $signed(a);
                sb = $signed(b);
                if (sa == int'(32'h8000_0000) && sb == -1) begin
                    q = sa; rem = 0;
                end else begin
                    q = sa / sb; rem = sa % sb;
                end
                r = {32'(rem), 32'(q)};
            end
            MDU_DIVU: begin
                if (b == 0) return {1'b0, 64'd0};
                r = {a % b, a / b};
            end
            default: return {1'b0, 64'd0};
        endcase
        return {1'b1, r};
    endfunction

    int          m_left;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [64:0] m_pend;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_pend[64]) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (Start) begin
            if (MDUOp == MDU_MULT || MDUOp == MDU_MULTU) begin
                m_left <= MC;
                m_pend <= calc(MDUOp, A, B);
            end else if (MDUOp == MDU_DIV || MDUOp == MDU_DIVU) begin
                m_left <= DC;
                m_pend <= calc(MDUOp, A, B);
            end else if (MDUOp == MDU_MTHI) begin
                m_hi <= A;
            end else if (MDUOp == MDU_MTLO) begin
                m_lo <= A;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare against the model mid-cycle, then step past the next edge.
    task automatic tick();
        @(negedge clk);
        chk("model_busy", 32'(Busy), 32'(m_left > 0));
        chk("model_hi", HI, m_hi);
        chk("model_lo", LO, m_lo);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        MDUOp = MDU_NONE;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        reset = 1'b0;
        Start = 1'b0;
        MDUOp = MDU_NONE;
        A     = '0;
        B     = '0;
        @(posedge clk); #1;
        tick();
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b1;
        tick();

        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n);
        chk("mult_busy_cycles", 32'(n), 32'(MC));
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFEB);

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("multu_busy_cycles", 32'(n), 32'(MC));
        chk("multu_hi", HI, 32'h0000_0001);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_busy_cycles", 32'(n), 32'(DC));
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("div_lo", LO, 32'hFFFF_FFFD);

        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        chk("divu_busy_cycles", 32'(n), 32'(DC));
        chk("divu_hi", HI, 32'd2);
        chk("divu_lo", LO, 32'd14);
        issue(MDU_DIVU, 32'd55, 32'd0);
        wait_idle(n);
        chk("divz_busy_cycles", 32'(n), 32'(DC));
        chk("divz_hi", HI, 32'd2);
        chk("divz_lo", LO, 32'd14);

        issue(MDU_NONE, 32'hDEAD_0001, 32'd1);
        issue(3'b111, 32'hDEAD_0002, 32'd1);
        chk("noop_busy", 32'(Busy), 32'd0);
        chk("noop_hi", HI, 32'd2);

        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_busy", 32'(Busy), 32'd0);
        issue(MDU_MTLO, 32'h9ABC_DEF0, 32'd0);
        chk("mtlo_lo", LO, 32'h9ABC_DEF0);
        chk("mtlo_busy", 32'(Busy), 32'd0);

        issue(MDU_MULT, 32'd6, 32'd7);
        issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
        wait_idle(n);
        chk("mthi_in_run_cycles", 32'(n + 1), 32'(MC));
        chk("mthi_in_run_hi", HI, 32'd0);
        chk("mthi_in_run_lo", LO, 32'd42);

        issue(MDU_MULT, 32'h0001_0000, 32'h0001_0000);
        issue(MDU_DIV, 32'd77, 32'd5);
        wait_idle(n);
        chk("div_in_run_cycles", 32'(n + 1), 32'(MC));
        chk("div_in_run_hi", HI, 32'd1);
        chk("div_in_run_lo", LO, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("div_in_run_no_second", 32'(Busy), 32'd0);
        chk("div_in_run_lo_kept", LO, 32'd0);

        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("div_ovf_hi", HI, 32'd0);
        chk("div_ovf_lo", LO, 32'h8000_0000);

        issue(MDU_MTHI, 32'hA5A5_A5A5, 32'd0);
        issue(MDU_DIV, 32'd1000, 32'd3);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(Busy), 32'd0);
        chk("async_rst_hi", HI, 32'd0);
        chk("async_rst_lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        issue(MDU_MULT, 32'd5, 32'hFFFF_FFFE);
        wait_idle(n);
        chk("post_rst_cycles", 32'(n), 32'(MC));
        chk("post_rst_hi", HI, 32'hFFFF_FFFF);
        chk("post_rst_lo", LO, 32'hFFFF_FFF6);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer sitting beside the single-cycle ALU in the EX stage. Accepts one mult/multu/div/divu request at a time, holds Busy for a fixed latency while the operation is in flight, then commits the 64-bit result to HI/LO. Also services mthi/mtlo writes. The pipeline controller stalls on Busy or Start for any MDU-touching instruction.

## Interface
- MULT_CYCLES, default 5: Busy cycles for mult/multu (1..15).
- DIV_CYCLES, default 10: Busy cycles for div/divu (1..15).

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- Start  input  1  request strobe, qualifies MDUOp for one cycle
- MDUOp  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 reserved = none
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo data)
- B  input  32  operand rt (divisor / multiplier)
- Busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- States: IDLE, RUN. Reset: state IDLE, Busy=0, HI=0, LO=0, counter=0, operand latches=0.
- IDLE, Start=1, MDUOp in {mult,multu,div,divu}: latch A, B, op; load counter with MULT_CYCLES or DIV_CYCLES; go RUN.
- IDLE, Start=1, MDUOp=mthi: HI<=A at that edge; mtlo: LO<=A. Stay IDLE. Start=1 with none/reserved: no effect.
- RUN: counter decrements each edge; on the edge where counter==1, commit result, go IDLE.
- Any Start in RUN, any op including mthi/mtlo: ignored, no latching, no queueing (upstream stalls guarantee it does not occur; block must still be safe).
- Arithmetic, on latched operands only:
  - mult: signed 32x32->64, HI=[63:32], LO=[31:0]; multu: unsigned.
  - div: LO=signed quotient truncated toward zero, HI=remainder with dividend's sign; divu: unsigned.
  - Divisor 0 (div/divu): HI and LO unchanged at commit; Busy still held DIV_CYCLES.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Reset asserted mid-RUN: immediately IDLE, Busy=0, HI=LO=0; in-flight op discarded.

## Timing
- Busy is a registered output, = (state==RUN).
- Start sampled at edge E0 -> Busy=1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES), HI/LO update at edge E0+N, same edge Busy falls.
- Back-to-back: Start in the first cycle with Busy=0 after completion is accepted; zero dead cycles.
- mthi/mtlo: HI/LO visible one cycle after the Start edge; Busy stays 0.
- A/B may change freely after the Start edge.
- HI/LO are readable combinationally at all times; during RUN they hold pre-operation values.

## Structure
- Shared package: MDUOp encodings (MDU_NONE..MDU_MTLO), state encoding, default latencies.
- One sub-module natural: mdu_core, purely combinational, takes latched operands + op, returns 64-bit {hi,lo} and a div_by_zero flag. mdu_ctrl owns state, counter, latches, HI/LO registers.
- Counter 4 bits; latencies >15 unsupported.

## Test plan
- Reset then mult, A=0xFFFFFFFD (-3), B=7 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=100, B=7 -> Busy 10 cycles, LO=14, HI=2; immediately following divu with B=0 -> Busy 10 cycles, HI/LO remain 2/14.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated one cycle later each, Busy never asserted; mthi issued during a mult RUN -> ignored, HI equals mult result.
- Start with div during mult RUN, A/B changing after E0 -> only original mult commits at cycle 5; second op never runs.
- Async reset pulse at cycle 3 of a div -> Busy=0, HI=LO=0 without waiting for clk; next mult runs normally.
